// File: rtl/uart_count_reporter.sv
// Samples a 14-bit counter on a trigger pulse, converts it to four BCD digits
// by sequential double dabble and sends them as ASCII text, one byte in flight.
module uart_count_reporter #(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [13:0] count,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, CONVERT, SEND, WAIT, FINISH} state_t;

  localparam logic [2:0] LAST_IDX = SEND_CRLF ? 3'd5 : 3'd3;

  state_t      state, state_next;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [11:0] bcd_adj;
  logic [3:0]  iter;
  logic [2:0]  idx;
  logic [13:0] clamped;
  logic [7:0]  char_cur;

  assign clamped = (count > 14'd9999) ? 14'd9999 : count;

  // With the input clamped to 9999 the thousands digit never exceeds 4 before
  // a shift, so only the lower three digits ever need the add-3 correction.
  always_comb begin
    bcd_adj = bcd[11:0];
    for (int d = 0; d < 3; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    case (idx)
      3'd0:    char_cur = {4'h3, bcd[15:12]};
      3'd1:    char_cur = {4'h3, bcd[11:8]};
      3'd2:    char_cur = {4'h3, bcd[7:4]};
      3'd3:    char_cur = {4'h3, bcd[3:0]};
      3'd4:    char_cur = 8'h0D;
      default: char_cur = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    tx_data    = 8'h00;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) state_next = CONVERT;
      end
      CONVERT: begin
        busy = 1'b1;
        if (iter == 4'd13) state_next = SEND;
      end
      SEND: begin
        busy    = 1'b1;
        tx_data = char_cur;
        if (!tx_busy) begin
          start      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        busy    = 1'b1;
        tx_data = char_cur;
        if (tx_done) state_next = (idx == LAST_IDX) ? FINISH : SEND;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin  <= '0;
      bcd  <= '0;
      iter <= '0;
      idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            bin  <= clamped;
            bcd  <= '0;
            iter <= '0;
            idx  <= '0;
          end
        end
        CONVERT: begin
          bin  <= {bin[12:0], 1'b0};
          bcd  <= {bcd[14:12], bcd_adj, bin[13]};
          iter <= iter + 4'd1;
        end
        WAIT: begin
          if (tx_done) idx <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_count_reporter.sv
// Directed bench for uart_count_reporter: two instances (with and without CRLF),
// each driven by a simple UART model that answers tx_done 10 cycles after start.
module tb_uart_count_reporter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic [13:0] count = '0;
  logic        hold_busy = 1'b0;

  logic       start0, start1, busy0, busy1, done0, done1;
  logic [7:0] data0, data1;
  logic       tx_busy0, tx_busy1;
  logic       mbusy0 = 1'b0, mbusy1 = 1'b0, mdone0 = 1'b0, mdone1 = 1'b0;
  int         mctr0 = 0, mctr1 = 0;

  int         cyc = 0;
  logic [7:0] q0[$], q1[$];
  int         sc0[$];
  int         n_start0 = 0, n_done0 = 0, n_done1 = 0, violations = 0;
  logic       await0 = 1'b0, await1 = 1'b0;

  int checks = 0, passed = 0;
  int trig_cyc, base0, base1, dbase0, dbase1, sbase0;

  assign tx_busy0 = mbusy0 | hold_busy;
  assign tx_busy1 = mbusy1 | hold_busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_count_reporter #(.SEND_CRLF(1'b1)) u_dut_crlf (
    .clk(clk), .reset(reset), .trigger(trigger), .count(count),
    .tx_busy(tx_busy0), .tx_done(mdone0),
    .start(start0), .tx_data(data0), .busy(busy0), .done(done0));

  uart_count_reporter #(.SEND_CRLF(1'b0)) u_dut_nocrlf (
    .clk(clk), .reset(reset), .trigger(trigger), .count(count),
    .tx_busy(tx_busy1), .tx_done(mdone1),
    .start(start1), .tx_data(data1), .busy(busy1), .done(done1));

  // UART models: busy from the edge after start, tx_done pulse in cycle start+10
  always @(posedge clk) begin
    if (start0) begin
      mbusy0 <= 1'b1; mctr0 <= 1;
    end else if (mctr0 != 0) begin
      if (mctr0 == 10) begin mdone0 <= 1'b0; mbusy0 <= 1'b0; mctr0 <= 0; end
      else begin mctr0 <= mctr0 + 1; if (mctr0 == 9) mdone0 <= 1'b1; end
    end
    if (start1) begin
      mbusy1 <= 1'b1; mctr1 <= 1;
    end else if (mctr1 != 0) begin
      if (mctr1 == 10) begin mdone1 <= 1'b0; mbusy1 <= 1'b0; mctr1 <= 0; end
      else begin mctr1 <= mctr1 + 1; if (mctr1 == 9) mdone1 <= 1'b1; end
    end
  end

  always @(negedge clk) begin
    if (start0) begin
      q0.push_back(data0);
      sc0.push_back(cyc);
      n_start0++;
      if (tx_busy0 || await0) violations++;
      await0 = 1'b1;
    end
    if (start1) begin
      q1.push_back(data1);
      if (tx_busy1 || await1) violations++;
      await1 = 1'b1;
    end
    if (mdone0) await0 = 1'b0;
    if (mdone1) await1 = 1'b0;
    if (done0) n_done0++;
    if (done1) n_done1++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic pulseTrigger(input logic [13:0] value, input logic [13:0] post);
    @(posedge clk); #1;
    count    = value;
    trigger  = 1'b1;
    trig_cyc = cyc;
    base0    = q0.size();
    base1    = q1.size();
    dbase0   = n_done0;
    dbase1   = n_done1;
    sbase0   = n_start0;
    @(posedge clk); #1;
    trigger = 1'b0;
    count   = post;
  endtask

  task automatic waitDone(input string tag, input bit retrig);
    bit got = 1'b0;
    bit rt  = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (retrig && !rt && (n_start0 - sbase0) == 2 && await0) begin
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        rt = 1'b1;
      end
      if (n_done0 != dbase0) begin got = 1'b1; break; end
    end
    checkOutput({tag, " done seen"}, {31'd0, got}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input string tag, input logic [13:0] value,
                               input logic [13:0] post, input bit retrig);
    pulseTrigger(value, post);
    waitDone(tag, retrig);
  endtask

  task automatic checkReport(input string tag, input int ch, input logic [7:0] exp [6], input int n);
    logic [7:0] b;
    int base, sz;
    base = (ch == 0) ? base0 : base1;
    sz   = (ch == 0) ? q0.size() : q1.size();
    checkOutput({tag, " byte count"}, sz - base, n);
    for (int i = 0; i < n; i++) begin
      b = 8'h00;
      if (base + i < sz) b = (ch == 0) ? q0[base + i] : q1[base + i];
      checkOutput($sformatf("%s byte%0d", tag, i), {24'd0, b}, {24'd0, exp[i]});
    end
  endtask

  initial begin
    logic [7:0] e1234 [6];
    logic [7:0] e0 [6];
    logic [7:0] e9 [6];
    logic [7:0] e507 [6];
    logic [7:0] e4321 [6];
    int seen, ns, rel;
    e1234 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    e0    = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    e9    = '{8'h39, 8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A};
    e507  = '{8'h30, 8'h35, 8'h30, 8'h37, 8'h0D, 8'h0A};
    e4321 = '{8'h34, 8'h33, 8'h32, 8'h31, 8'h0D, 8'h0A};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset start", {31'd0, start0}, 32'd0);
    checkOutput("reset tx_data", {24'd0, data0}, 32'd0);
    checkOutput("reset busy", {31'd0, busy0}, 32'd0);
    checkOutput("reset done", {31'd0, done0}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    applyStimulus("r1234", 14'd1234, 14'd1234, 1'b0);
    checkReport("r1234", 0, e1234, 6);
    checkOutput("r1234 latency", (sc0.size() > base0) ? sc0[base0] - trig_cyc : -1, 32'd15);
    checkOutput("r1234 done pulses", n_done0 - dbase0, 32'd1);
    checkOutput("r1234 busy after", {31'd0, busy0}, 32'd0);

    applyStimulus("r0", 14'd0, 14'd0, 1'b0);
    checkReport("r0", 0, e0, 6);
    applyStimulus("r12000", 14'd12000, 14'd12000, 1'b0);
    checkReport("r12000", 0, e9, 6);
    applyStimulus("r16383", 14'd16383, 14'd16383, 1'b0);
    checkReport("r16383", 0, e9, 6);

    applyStimulus("r507", 14'd507, 14'd507, 1'b0);
    checkReport("r507 crlf", 0, e507, 6);
    checkReport("r507 nocrlf", 1, e507, 4);
    checkOutput("r507 nocrlf done pulses", n_done1 - dbase1, 32'd1);

    applyStimulus("retrig", 14'd1234, 14'd4321, 1'b1);
    repeat (40) begin @(posedge clk); #1; end
    checkReport("retrig", 0, e1234, 6);
    checkOutput("retrig done pulses", n_done0 - dbase0, 32'd1);
    checkOutput("retrig idle busy", {31'd0, busy0}, 32'd0);

    hold_busy = 1'b1;
    pulseTrigger(14'd4321, 14'd4321);
    while (cyc < trig_cyc + 65) begin @(posedge clk); #1; end
    checkOutput("hold no start", n_start0 - sbase0, 32'd0);
    rel = cyc;
    hold_busy = 1'b0;
    waitDone("hold", 1'b0);
    checkOutput("hold first start", (sc0.size() > base0) ? sc0[base0] - rel : -1, 32'd0);
    checkReport("hold", 0, e4321, 6);

    pulseTrigger(14'd1234, 14'd1234);
    seen = 0;
    for (int k = 0; k < 2000 && seen < 2; k++) begin
      @(negedge clk);
      if (mdone0) seen++;
    end
    checkOutput("midreset tx_done seen", seen, 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset start", {31'd0, start0}, 32'd0);
    checkOutput("midreset tx_data", {24'd0, data0}, 32'd0);
    checkOutput("midreset busy", {31'd0, busy0}, 32'd0);
    checkOutput("midreset done", {31'd0, done0}, 32'd0);
    ns = n_start0;
    repeat (40) begin @(posedge clk); #1; end
    checkOutput("midreset no start", n_start0 - ns, 32'd0);
    checkOutput("midreset no done", n_done0 - dbase0, 32'd0);

    applyStimulus("fresh", 14'd1234, 14'd1234, 1'b0);
    checkReport("fresh", 0, e1234, 6);
    checkOutput("fresh latency", (sc0.size() > base0) ? sc0[base0] - trig_cyc : -1, 32'd15);

    checkOutput("protocol violations", violations, 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
